// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate data cache
// that sits between the pipeline's MEM-stage data-request interface and physical memory.
//
// Ports:
//   i_clk, i_rst_n     clock; synchronous active-low reset
//   i_req_rw           request valid, held by the initiator until o_rw_resp
//   i_wr_en            1 = store, 0 = load
//   i_addr             byte address
//   i_wdata, i_byte_en store data and byte mask ([1] = high byte)
//   o_rw_resp          one-cycle completion pulse
//   o_rdata            load data; holds its last value outside the response cycle
//   o_pmem_read        line-fill request (line-aligned o_pmem_addr)
//   o_pmem_write       word write-through request (word-aligned o_pmem_addr)
//   o_pmem_addr, o_pmem_wdata, o_pmem_wmask  physical-memory request fields
//   i_pmem_rdata       fill line data
//   i_pmem_resp        one-cycle physical-memory completion
module dcache_responder #(
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned OFFSET_BITS = 4,
  parameter int unsigned TAG_BITS    = 16 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req_rw,
  input  logic                          i_wr_en,
  input  logic [15:0]                   i_addr,
  input  logic [15:0]                   i_wdata,
  input  logic [1:0]                    i_byte_en,
  output logic                          o_rw_resp,
  output logic [15:0]                   o_rdata,
  output logic                          o_pmem_read,
  output logic                          o_pmem_write,
  output logic [15:0]                   o_pmem_addr,
  output logic [15:0]                   o_pmem_wdata,
  output logic [1:0]                    o_pmem_wmask,
  input  logic [(8 << OFFSET_BITS)-1:0] i_pmem_rdata,
  input  logic                          i_pmem_resp
);

  localparam int unsigned Lines    = 1 << INDEX_BITS;
  localparam int unsigned LineBits = 8 << OFFSET_BITS;

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StResp} state_e;

  state_e r_state, w_state_next;

  // Request captured at acceptance; later input changes are ignored.
  logic [15:0] r_addr;
  logic        r_wr_en;
  logic [15:0] r_wdata;
  logic [1:0]  r_byte_en;
  logic        r_hit;
  logic [15:0] r_rdata;

  logic [Lines-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [Lines];
  logic [LineBits-1:0] r_data [Lines];

  // Lookup on the live request, used only at the acceptance edge.
  logic [TAG_BITS-1:0]    w_in_tag;
  logic [INDEX_BITS-1:0]  w_in_index;
  logic [OFFSET_BITS-2:0] w_in_word;
  logic [LineBits-1:0]    w_in_line;
  logic                   w_hit;
  logic [15:0]            w_hit_word;

  assign w_in_tag   = i_addr[15 -: TAG_BITS];
  assign w_in_index = i_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_in_word  = i_addr[OFFSET_BITS-1:1];
  assign w_in_line  = r_data[w_in_index];
  assign w_hit      = r_valid[w_in_index] && (r_tag[w_in_index] == w_in_tag);
  assign w_hit_word = w_in_line[{w_in_word, 4'b0000} +: 16];

  // Fields of the latched request.
  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_index;
  logic [OFFSET_BITS-2:0] w_word;
  logic                   w_unused_addr0;

  assign w_tag          = r_addr[15 -: TAG_BITS];
  assign w_index        = r_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_word         = r_addr[OFFSET_BITS-1:1];
  assign w_unused_addr0 = r_addr[0];  // byte lane within a word never selects a word

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_rw_resp    = 1'b0;
    o_pmem_read  = 1'b0;
    o_pmem_write = 1'b0;
    o_pmem_addr  = '0;
    o_pmem_wdata = '0;
    o_pmem_wmask = '0;
    unique case (r_state)
      StIdle: begin
        if (i_req_rw) begin
          if (i_wr_en)    w_state_next = StWrite;
          else if (w_hit) w_state_next = StResp;
          else            w_state_next = StFill;
        end
      end
      StFill: begin
        o_pmem_read = 1'b1;
        o_pmem_addr = {r_addr[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        if (i_pmem_resp) w_state_next = StResp;
      end
      StWrite: begin
        o_pmem_write = 1'b1;
        o_pmem_addr  = {r_addr[15:1], 1'b0};
        o_pmem_wdata = r_wdata;
        o_pmem_wmask = r_byte_en;
        if (i_pmem_resp) w_state_next = StResp;
      end
      // Always return through IDLE so a still-held req_rw is not accepted twice.
      StResp: begin
        o_rw_resp    = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_rdata = r_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid   <= '0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wdata   <= '0;
      r_byte_en <= '0;
      r_hit     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req_rw) begin
            r_addr    <= i_addr;
            r_wr_en   <= i_wr_en;
            r_wdata   <= i_wdata;
            r_byte_en <= i_byte_en;
            r_hit     <= w_hit;
            if (!i_wr_en && w_hit) r_rdata <= w_hit_word;
          end
        end
        StFill: begin
          if (i_pmem_resp) begin
            r_data[w_index]  <= i_pmem_rdata;
            r_tag[w_index]   <= w_tag;
            r_valid[w_index] <= 1'b1;
            r_rdata          <= i_pmem_rdata[{w_word, 4'b0000} +: 16];
          end
        end
        StWrite: begin
          // Only lines present at acceptance are updated; misses never allocate.
          if (i_pmem_resp && r_hit && r_wr_en) begin
            if (r_byte_en[0]) r_data[w_index][{w_word, 4'b0000} +: 8] <= r_wdata[7:0];
            if (r_byte_en[1]) r_data[w_index][{w_word, 4'b1000} +: 8] <= r_wdata[15:8];
          end
        end
        StResp: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed testbench for dcache_responder: cold miss, hit, byte store hit, store
// miss without allocation, conflict eviction, zero-mask store and reset mid-fill.
module tb_dcache_responder;

  localparam int PmemLat = 3;   // cycles a pmem strobe is seen before the response
  localparam int HitLat  = 1;   // edges from request to rw_resp on a hit
  localparam int MissLat = PmemLat + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_rw;
  logic         wr_en;
  logic [15:0]  addr;
  logic [15:0]  wdata;
  logic [1:0]   byte_en;
  logic         rw_resp;
  logic [15:0]  rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_addr;
  logic [15:0]  pmem_wdata;
  logic [1:0]   pmem_wmask;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dcache_responder u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_rw    (req_rw),
    .i_wr_en     (wr_en),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_byte_en   (byte_en),
    .o_rw_resp   (rw_resp),
    .o_rdata     (rdata),
    .o_pmem_read (pmem_read),
    .o_pmem_write(pmem_write),
    .o_pmem_addr (pmem_addr),
    .o_pmem_wdata(pmem_wdata),
    .o_pmem_wmask(pmem_wmask),
    .i_pmem_rdata(pmem_rdata),
    .i_pmem_resp (pmem_resp)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete request. exp_paddr/wdata/wmask are checked on the first strobe cycle.
  task automatic xact(input string tag, input logic wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic [1:0] be,
                      input logic exp_rd, input logic exp_wr, input int exp_lat,
                      input logic [15:0] exp_paddr, input logic [127:0] line,
                      input logic [15:0] exp_rdata);
    int   scnt = 0;
    int   lat  = 0;
    logic done = 1'b0;
    logic seen_r = 1'b0;
    logic seen_w = 1'b0;
    logic [15:0] rd = '0;
    req_rw  = 1'b1;
    wr_en   = wr;
    addr    = a;
    wdata   = wd;
    byte_en = be;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) check_eq({tag, " strobes both"}, 1, 0);
      if (pmem_read || pmem_write) begin
        if (scnt == 0) begin
          check_eq({tag, " pmem_addr"}, pmem_addr, exp_paddr);
          if (pmem_write) begin
            check_eq({tag, " pmem_wdata"}, pmem_wdata, wd);
            check_eq({tag, " pmem_wmask"}, pmem_wmask, be);
          end
        end
        seen_r |= pmem_read;
        seen_w |= pmem_write;
        scnt++;
        if (scnt == PmemLat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = line;
        end
      end
      if (rw_resp) begin
        done = 1'b1;
        lat  = c;
        rd   = rdata;
      end
    end
    check_eq({tag, " completed"}, done, 1);
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " pmem_read seen"}, seen_r, exp_rd);
    check_eq({tag, " pmem_write seen"}, seen_w, exp_wr);
    if (!wr) check_eq({tag, " rdata"}, rd, exp_rdata);
    // Initiator keeps req_rw high through the response cycle, dropping it afterwards.
    @(posedge clk);
    #1;
    check_eq({tag, " resp single pulse"}, rw_resp, 0);
    req_rw = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, " no double accept"}, {rw_resp, pmem_read, pmem_write}, 0);
    if (!wr) check_eq({tag, " rdata held"}, rdata, exp_rdata);
  endtask

  logic [127:0] line_a;  // line for 0x1230, word2 = BEEF
  logic [127:0] line_b;  // line for 0x4000
  logic [127:0] line_c;  // line for 0x3230, word2 = C0DE

  initial begin
    line_a = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    line_b = {16'hA007, 16'hA006, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000};
    line_c = {16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC0DE, 16'hC001, 16'hC000};
    rst_n      = 1'b0;
    req_rw     = 1'b0;
    wr_en      = 1'b0;
    addr       = '0;
    wdata      = '0;
    byte_en    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset strobes", {rw_resp, pmem_read, pmem_write}, 0);
    check_eq("reset rdata", rdata, 0);
    check_eq("reset pmem fields", {pmem_addr, pmem_wdata, pmem_wmask}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, then hit.
    xact("t1 cold miss", 1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 1'b0, MissLat, 16'h1230,
         line_a, 16'hBEEF);
    xact("t2 hit", 1'b0, 16'h1234, 16'h0, 2'b00, 1'b0, 1'b0, HitLat, 16'h0, line_a, 16'hBEEF);

    // High-byte store hit merges into the cached word.
    xact("t3 store", 1'b1, 16'h1235, 16'h5A00, 2'b10, 1'b0, 1'b1, MissLat, 16'h1234,
         line_a, 16'h0);
    xact("t3 read", 1'b0, 16'h1234, 16'h0, 2'b00, 1'b0, 1'b0, HitLat, 16'h0, line_a, 16'h5AEF);

    // Zero-mask store still goes to memory but leaves the cache alone.
    xact("t3b store m00", 1'b1, 16'h1234, 16'hFFFF, 2'b00, 1'b0, 1'b1, MissLat, 16'h1234,
         line_a, 16'h0);
    xact("t3b read", 1'b0, 16'h1234, 16'h0, 2'b00, 1'b0, 1'b0, HitLat, 16'h0, line_a, 16'h5AEF);

    // Store miss does not allocate.
    xact("t4 store miss", 1'b1, 16'h4000, 16'h1111, 2'b11, 1'b0, 1'b1, MissLat, 16'h4000,
         line_b, 16'h0);
    xact("t4 read", 1'b0, 16'h4000, 16'h0, 2'b00, 1'b1, 1'b0, MissLat, 16'h4000,
         line_b, 16'hA000);

    // Conflict eviction on index 3.
    xact("t5 evict", 1'b0, 16'h3234, 16'h0, 2'b00, 1'b1, 1'b0, MissLat, 16'h3230,
         line_c, 16'hC0DE);
    xact("t5 reread", 1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 1'b0, MissLat, 16'h1230,
         line_a, 16'hBEEF);

    // Reset while a fill is outstanding.
    req_rw = 1'b1;
    wr_en  = 1'b0;
    addr   = 16'h5234;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(posedge clk);
        #1;
        seen = pmem_read;
      end
      check_eq("t6 fill started", seen, 1);
    end
    repeat (5) @(posedge clk);
    #1;
    check_eq("t6 fill held", {pmem_read, pmem_addr}, {1'b1, 16'h5230});
    rst_n  = 1'b0;
    req_rw = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6 after reset", {rw_resp, pmem_read, pmem_write}, 0);
    rst_n      = 1'b1;
    pmem_resp  = 1'b1;
    pmem_rdata = line_c;
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("t6 late resp ignored", {rw_resp, pmem_read, pmem_write}, 0);
      @(posedge clk);
      #1;
    end
    xact("t6 read", 1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 1'b0, MissLat, 16'h1230,
         line_a, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Memory-side responder for the pipeline's data-request interface (req_rw / wr_en / addr in, rw_resp / rdata out).
- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and physical memory.
- Serves all data loads, stores and trap-vector reads. The two-phase STI/LDI indirection stays in the initiator: each phase arrives here as an independent request.

Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines).
- OFFSET_BITS, 4, log2 of line size in bytes (16 B line = 128 bits).
- TAG_BITS, 16-INDEX_BITS-OFFSET_BITS (default 9), tag width per line.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_rw  in  1  request valid; held high by initiator until rw_resp is seen.
- wr_en  in  1  1 = store, 0 = load; valid only while req_rw=1.
- addr  in  16  byte address (lc3b_word).
- wdata  in  16  store data.
- byte_en  in  2  store byte mask, [1]=high byte, [0]=low byte; ignored on loads.
- rw_resp  out  1  one-cycle completion pulse.
- rdata  out  16  load data; valid only when rw_resp=1.
- pmem_read  out  1  line-fill request to physical memory.
- pmem_write  out  1  word write-through request.
- pmem_addr  out  16  line-aligned address (low OFFSET_BITS zero) on read; word address (bit0=0) on write.
- pmem_wdata  out  16  write-through data.
- pmem_wmask  out  2  write-through byte mask.
- pmem_rdata  in  128  fill line data.
- pmem_resp  in  1  one-cycle physical-memory completion.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE and all valid bits clear.
  - rw_resp, pmem_read and pmem_write are 0; rdata, pmem_addr, pmem_wdata and pmem_wmask are 0.
  - Tag/data arrays need no reset.
- Request acceptance:
  - A request is accepted only in IDLE, at the first posedge with req_rw=1.
  - At acceptance, addr, wr_en, wdata and byte_en are latched. Input changes after acceptance are ignored.
- Address split: tag = addr[15:15-TAG_BITS+1], index = next INDEX_BITS, offset = addr[OFFSET_BITS-1:0]. Word select uses offset[3:1]; addr[0] is ignored for word selection.
- Hit is defined as valid[index] && tag match.
- States:
  - IDLE: on acceptance go to RESP (read hit), FILL (read miss) or WRITE (any store).
  - FILL:
    - pmem_read=1 and pmem_addr = {addr[15:4],4'b0}, held until pmem_resp.
    - On pmem_resp: write the line, set tag and valid, capture rdata = selected word of pmem_rdata, go to RESP.
  - WRITE:
    - pmem_write=1, pmem_addr={addr[15:1],1'b0}, pmem_wdata=wdata, pmem_wmask=byte_en, all held until pmem_resp.
    - On pmem_resp: if hit, merge the enabled bytes into the cached word; if miss, do not allocate. Go to RESP.
  - RESP: rw_resp=1 for exactly one cycle, rdata held stable; next state is always IDLE.
- Latency:
  - Read hit: rw_resp in the 2nd cycle after req_rw first high (accept edge + RESP cycle).
  - Read miss / store: pmem latency + 2 cycles.
- Back-to-back requests:
  - The initiator deasserts req_rw the cycle after rw_resp. The RESP→IDLE cycle guarantees that a held req_rw is never double-accepted.
  - A new req_rw in the first IDLE cycle is a new request.
- Hit is evaluated against the state at acceptance. A store to a line that is filled later is not retroactively merged (no-write-allocate).
- byte_en=2'b00 on a store: the pmem write is still issued with mask 00, and the cache is unchanged.
- rdata keeps its last value outside RESP. It is not forced to zero.
- pmem_read and pmem_write are never high together.
- pmem_resp outside FILL/WRITE is ignored.
- Reset mid-FILL or mid-WRITE:
  - The operation is abandoned, pmem strobes drop the next cycle, and no rw_resp is issued.
  - No valid bit is set; a late pmem_resp is ignored.
- Reset takes priority over every other event at the same edge.

Test Plan:
1. Cold read miss: reset, then req_rw=1, wr_en=0, addr=0x1234. Expect pmem_read with pmem_addr=0x1230. Respond with pmem_rdata word2=0xBEEF → rw_resp one pulse, rdata=0xBEEF, line 3 valid.
2. Read hit: repeat the read of 0x1234 → no pmem_read, rw_resp exactly 2 cycles after req_rw rises, rdata=0xBEEF.
3. Byte store hit: store addr=0x1235, wdata=0x5A00, byte_en=10 → pmem_write with addr 0x1234, wmask=10. After pmem_resp, the read of 0x1234 hits and returns 0x5AEF.
4. Store miss, no allocate: store 0x4000, wdata=0x1111, byte_en=11 → pmem_write issued. The following read of 0x4000 must issue pmem_read (miss).
5. Conflict eviction: read 0x1234 (line cached), then read 0x3234 (same index, different tag) → fill; the re-read of 0x1234 misses again.
6. Reset mid-fill with held request: assert req_rw, hold pmem_resp low 5 cycles, rst_n=0 for one cycle. Expect pmem_read=0 after reset, no rw_resp, and a later pmem_resp ignored. The read of 0x1234 then misses.
